// File: rtl/fetch_tagger.sv
// Instruction fetch front end: PC, IMEM req/ack, rolling tags, issue pulse.
// Optional stall counter (o_stall_cnt) when FETCH_PERF_EN is defined.
module fetch_tagger #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TAG_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_pc,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_stall,
    input  logic             i_retire,
    output logic             o_en,
    output logic [31:0]      o_instr,
    output logic [31:0]      o_next_pc,
    output logic [TAG_W-1:0] o_tag
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      o_stall_cnt
`endif
);

    // Handshake: o_imem_req rises with o_imem_addr and both hold until a
    // cycle with i_imem_ack high; that cycle completes the transfer.
    localparam int unsigned TAGS = 2 ** TAG_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_addr;
    logic             r_req;
    logic [31:0]      r_hold;
    logic [TAG_W-1:0] r_tag_ctr;
    logic [TAG_W:0]   r_inflight;
    logic             r_en;
    logic [31:0]      r_instr;
    logic [31:0]      r_next_pc;
    logic [TAG_W-1:0] r_tag;

    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_plus4;
    logic        w_ack;
    logic        w_issuable;
    logic        w_issue;
    logic [31:0] w_word;

    assign w_redir_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_ack      = i_imem_ack && r_req;
    assign w_issuable = !i_stall && (r_inflight < (TAG_W+1)'(TAGS)) && !i_redirect_valid;
    assign w_issue    = w_issuable && (((r_state == S_FETCH) && w_ack) || (r_state == S_HOLD));
    assign w_word     = (r_state == S_HOLD) ? r_hold : i_imem_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_hold     <= 32'h0000_0000;
            r_tag_ctr  <= '0;
            r_inflight <= '0;
            r_en       <= 1'b0;
            r_instr    <= 32'h0000_0013;
            r_next_pc  <= 32'h0000_0000;
            r_tag      <= '0;
        end else begin
            r_en <= w_issue;
            if (w_issue) begin
                r_instr   <= w_word;
                r_next_pc <= w_pc_plus4;
                r_tag     <= r_tag_ctr;
                r_tag_ctr <= r_tag_ctr + TAG_W'(1);
            end

            // Issue and retire together leave the count unchanged.
            if (w_issue && !i_retire) begin
                r_inflight <= r_inflight + (TAG_W+1)'(1);
            end else if (!w_issue && i_retire && (r_inflight != '0)) begin
                r_inflight <= r_inflight - (TAG_W+1)'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    if (i_redirect_valid) begin
                        r_pc   <= w_redir_pc;
                        r_addr <= w_redir_pc;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                S_FETCH: begin
                    if (i_redirect_valid) begin
                        r_pc <= w_redir_pc;
                        if (w_ack) begin
                            r_addr <= w_redir_pc;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_ack) begin
                        if (w_issuable) begin
                            r_pc   <= w_pc_plus4;
                            r_addr <= w_pc_plus4;
                        end else begin
                            r_hold  <= i_imem_rdata;
                            r_req   <= 1'b0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_addr  <= w_redir_pc;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (w_issuable) begin
                        r_pc    <= w_pc_plus4;
                        r_addr  <= w_pc_plus4;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // The outstanding request stays on the bus; its data is dropped.
                    if (i_redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (w_ack) begin
                        r_addr  <= i_redirect_valid ? w_redir_pc : r_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = (r_state == S_HOLD) || ((r_state == S_FETCH) && w_ack && !w_issuable);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= 32'h0000_0000;
        end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;
    assign o_en        = r_en;
    assign o_instr     = r_instr;
    assign o_next_pc   = r_next_pc;
    assign o_tag       = r_tag;

endmodule

// File: tb/tb_fetch_tagger.sv
// Bench for fetch_tagger: directed stimulus, a program-order model checked
// every cycle, and hand-computed literal expectations at key points.
module tb_fetch_tagger;

    logic        i_clk;
    logic        i_rst;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_retire;
    logic        o_en;
    logic [31:0] o_instr;
    logic [31:0] o_next_pc;
    logic [3:0]  o_tag;
`ifdef FETCH_PERF_EN
    logic [31:0] o_stall_cnt;
`endif

    fetch_tagger #(.RESET_PC(32'h0000_0000), .TAG_W(4)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ack       (i_imem_ack),
        .i_imem_rdata     (i_imem_rdata),
        .i_stall          (i_stall),
        .i_retire         (i_retire),
        .o_en             (o_en),
        .o_instr          (o_instr),
        .o_next_pc        (o_next_pc),
        .o_tag            (o_tag)
`ifdef FETCH_PERF_EN
        ,
        .o_stall_cnt      (o_stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = {a[15:0] ^ 16'hC3A5, a[15:0]};
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic st, input logic rt, input logic rv,
                        input logic [31:0] rpc, input logic ak);
        @(posedge i_clk);
        #1;
        i_stall          = st;
        i_retire         = rt;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
        i_imem_ack       = ak && o_imem_req;
        i_imem_rdata     = mem_word(o_imem_addr);
    endtask

    // ---------------- model + scoreboard ----------------
    // Program-order view: words leave in address order from the current fetch
    // point, a redirect moves that point, and at most 16 tags are outstanding.
    logic [31:0] exp_q[$];
    logic        model_on = 1'b0;
    logic        m_idle, m_held, m_drain, m_en_pending;
    logic [31:0] m_fetch_pc, m_held_addr, m_drain_addr;
    logic [3:0]  m_tag;
    int          m_inflight;
    int          m_stall;
    logic        m_ack, m_issuable, m_issue;
    logic [31:0] m_a;

    always @(negedge i_clk) begin
        if (model_on) begin
            check("o_en", {31'd0, o_en}, {31'd0, m_en_pending});
            if (m_en_pending && o_en && exp_q.size() > 0) begin
                m_a = exp_q.pop_front();
                check("o_instr", o_instr, mem_word(m_a));
                check("o_next_pc", o_next_pc, m_a + 32'd4);
                check("o_tag", {28'd0, o_tag}, {28'd0, m_tag});
                m_tag = m_tag + 4'd1;
            end
            check("o_imem_req", {31'd0, o_imem_req}, {31'd0, !m_idle && !m_held});
            if (o_imem_req)
                check("o_imem_addr", o_imem_addr, m_drain ? m_drain_addr : m_fetch_pc);

            m_ack      = i_imem_ack && o_imem_req;
            m_issuable = !i_stall && (m_inflight < 16) && !i_redirect_valid;
            m_issue    = 1'b0;
            if (!m_idle && (m_held || (!m_drain && m_ack && !m_issuable)))
                m_stall++;

            if (m_idle) begin
                m_idle = 1'b0;
                if (i_redirect_valid) m_fetch_pc = i_redirect_pc & ~32'd3;
            end else if (i_redirect_valid) begin
                if (!m_held && !m_ack && !m_drain) begin
                    m_drain      = 1'b1;
                    m_drain_addr = m_fetch_pc;
                end else if (m_ack) begin
                    m_drain = 1'b0;
                end
                m_held     = 1'b0;
                m_fetch_pc = i_redirect_pc & ~32'd3;
            end else if (m_drain) begin
                if (m_ack) m_drain = 1'b0;
            end else if (m_held) begin
                if (m_issuable) begin
                    m_issue = 1'b1;
                    exp_q.push_back(m_held_addr);
                    m_held     = 1'b0;
                    m_fetch_pc = m_held_addr + 32'd4;
                end
            end else if (m_ack) begin
                if (m_issuable) begin
                    m_issue = 1'b1;
                    exp_q.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end else begin
                    m_held      = 1'b1;
                    m_held_addr = m_fetch_pc;
                end
            end

            if (m_issue && !i_retire) m_inflight++;
            else if (!m_issue && i_retire && m_inflight > 0) m_inflight--;
            m_en_pending = m_issue;
        end
    end

    localparam logic [2:0] TAIL [16] = '{3'b001, 3'b011, 3'b001, 3'b101,
                                         3'b100, 3'b010, 3'b000, 3'b011,
                                         3'b011, 3'b001, 3'b110, 3'b010,
                                         3'b001, 3'b011, 3'b000, 3'b001};

    initial begin
        m_idle = 1'b1; m_held = 1'b0; m_drain = 1'b0; m_en_pending = 1'b0;
        m_fetch_pc = 32'h0; m_held_addr = 32'h0; m_drain_addr = 32'h0;
        m_tag = 4'd0; m_inflight = 0; m_stall = 0;
        i_rst = 1'b1; i_stall = 1'b0; i_retire = 1'b0; i_redirect_valid = 1'b0;
        i_redirect_pc = 32'h0; i_imem_ack = 1'b0; i_imem_rdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        i_retire = 1'b1;          // retire with nothing in flight must be ignored
        model_on = 1'b1;

        // Reset state (IDLE cycle)
        check("rst_o_en", {31'd0, o_en}, 32'd0);
        check("rst_req", {31'd0, o_imem_req}, 32'd0);
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_instr", o_instr, 32'h0000_0013);
        check("rst_next_pc", o_next_pc, 32'h0);
        check("rst_tag", {28'd0, o_tag}, 32'd0);

        // T1: back-to-back same-cycle acks
        step(0, 0, 0, 0, 1);
        check("t1_req", {31'd0, o_imem_req}, 32'd1);
        check("t1_addr", o_imem_addr, 32'h0);
        step(0, 0, 0, 0, 1);
        check("t1_en0", {31'd0, o_en}, 32'd1);
        check("t1_instr0", o_instr, 32'h0050_0093);
        check("t1_npc0", o_next_pc, 32'h4);
        check("t1_tag0", {28'd0, o_tag}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("t1_instr1", o_instr, 32'h0010_0113);
        check("t1_npc1", o_next_pc, 32'h8);
        check("t1_tag1", {28'd0, o_tag}, 32'd1);
        step(0, 0, 0, 0, 1);

        // T2: stall on the word at 0x10
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("t2_hold_req", {31'd0, o_imem_req}, 32'd0);
        check("t2_hold_en", {31'd0, o_en}, 32'd0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t2_en", {31'd0, o_en}, 32'd1);
        check("t2_instr", o_instr, 32'hC3B5_0010);
        check("t2_npc", o_next_pc, 32'h14);
        check("t2_tag", {28'd0, o_tag}, 32'd4);

        // T5: redirect with same-cycle ack, then issue+retire together
        step(0, 0, 1, 32'h101, 1);
        step(0, 1, 0, 0, 1);
        check("t5_en", {31'd0, o_en}, 32'd0);
        check("t5_addr", o_imem_addr, 32'h100);

        // T3: fill all tags; the word at 0x130 waits until one retire
        repeat (12) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t3_full_en", {31'd0, o_en}, 32'd0);
        check("t3_full_req", {31'd0, o_imem_req}, 32'd0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t3_en", {31'd0, o_en}, 32'd1);
        check("t3_tag_wrap", {28'd0, o_tag}, 32'd1);
        check("t3_npc", o_next_pc, 32'h134);
        check("t3_instr", o_instr, 32'hC295_0130);

        // T4: redirect while request at 0x134 is unacked, ack 3 cycles later
        step(0, 0, 1, 32'h203, 0);
        step(0, 1, 0, 0, 0);
        check("t4_drain_addr", o_imem_addr, 32'h134);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t4_en", {31'd0, o_en}, 32'd0);
        check("t4_addr", o_imem_addr, 32'h200);
        step(1, 0, 0, 0, 1);
        check("t4_npc", o_next_pc, 32'h204);
        check("t4_instr", o_instr, 32'hC1A5_0200);

        // Redirect out of HOLD discards the held word
        step(1, 0, 1, 32'h300, 0);
        step(0, 0, 0, 0, 1);
        check("hold_redir_addr", o_imem_addr, 32'h300);
        step(0, 0, 0, 0, 0);
        check("hold_redir_tag", {28'd0, o_tag}, 32'd3);
        check("hold_redir_npc", o_next_pc, 32'h304);

        // Mixed stall/retire/ack pattern, checked by the model
        for (int i = 0; i < 16; i++)
            step(TAIL[i][2], TAIL[i][1], 0, 0, TAIL[i][0]);

        step(0, 0, 1, 32'h400, 0);
        step(0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        check("stall_cnt", o_stall_cnt, m_stall);
`endif
        // Asynchronous reset mid-request
        model_on = 1'b0;
        check("pre_rst_req", {31'd0, o_imem_req}, 32'd1);
        #1 i_rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, o_imem_req}, 32'd0);
        check("async_rst_addr", o_imem_addr, 32'h0);
        check("leftover_issues", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
